// File: rtl/w_sched_stream.sv
// w_sched_stream: SHA-2 message-schedule expander.
// Loads 16 message words serially into a 16-entry sliding window, then streams
// W[0..ROUNDS-1] under valid/ready. Each accepted output word shifts the window
// and appends W[t+16] = s1(win[14]) + win[9] + s0(win[1]) + win[0].
// WORD_W=32 selects the SHA-256 sigmas; WORD_W=64 selects the SHA-512 sigmas.
module w_sched_stream #(
  parameter int WORD_W = 32,
  parameter int ROUNDS = 64
) (
  input  logic              clock,
  input  logic              reset,
  input  logic              clear,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              out_valid,
  output logic [WORD_W-1:0] out_data,
  input  logic              out_ready,
  output logic              out_last,
  output logic              busy
);

  localparam int T_W = $clog2(ROUNDS);
  localparam logic [T_W-1:0] T_LAST = T_W'(ROUNDS - 1);

  typedef enum logic [1:0] {
    ST_IDLE   = 2'd0,
    ST_LOAD   = 2'd1,
    ST_EXPAND = 2'd2
  } state_t;

  state_t            state_q, state_d;
  logic [4:0]        ld_cnt_q, ld_cnt_d;
  logic [T_W-1:0]    t_q, t_d;
  logic [WORD_W-1:0] win_q [16];
  logic [WORD_W-1:0] win_d [16];
  logic              in_ready_q, in_ready_d;
  logic              out_valid_q, out_valid_d;
  logic              out_last_q, out_last_d;
  logic              busy_q, busy_d;
  logic [WORD_W-1:0] w_next_s;

  // Rotate right by a constant amount.
  function automatic logic [WORD_W-1:0] rotr(input logic [WORD_W-1:0] x, input int unsigned n);
    return (x >> n) | (x << (WORD_W - n));
  endfunction

  // Small sigma 0 for the selected word width.
  function automatic logic [WORD_W-1:0] sig0(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) begin
      return rotr(x, 1) ^ rotr(x, 8) ^ (x >> 7);
    end else begin
      return rotr(x, 7) ^ rotr(x, 18) ^ (x >> 3);
    end
  endfunction

  // Small sigma 1 for the selected word width.
  function automatic logic [WORD_W-1:0] sig1(input logic [WORD_W-1:0] x);
    if (WORD_W == 64) begin
      return rotr(x, 19) ^ rotr(x, 61) ^ (x >> 6);
    end else begin
      return rotr(x, 17) ^ rotr(x, 19) ^ (x >> 10);
    end
  endfunction

  // Next schedule word from the current window (W[t+16]), wraps mod 2^WORD_W.
  always_comb begin
    w_next_s = sig1(win_q[14]) + win_q[9] + sig0(win_q[1]) + win_q[0];
  end

  // Next-state, counter, window and registered-output computation.
  always_comb begin
    state_d = state_q;
    ld_cnt_d = ld_cnt_q;
    t_d = t_q;
    win_d = win_q;
    if (clear) begin
      // Abort wins over any same-cycle handshake; window contents are left as-is.
      state_d = ST_LOAD;
      ld_cnt_d = 5'd0;
      t_d = '0;
    end else begin
      case (state_q)
        ST_IDLE: begin
          state_d = ST_LOAD;
        end
        ST_LOAD: begin
          if (in_valid) begin
            for (int k = 0; k < 15; k++) begin
              win_d[k] = win_q[k+1];
            end
            win_d[15] = in_data;
            if (ld_cnt_q == 5'd15) begin
              state_d = ST_EXPAND;
              ld_cnt_d = 5'd0;
            end else begin
              ld_cnt_d = ld_cnt_q + 5'd1;
            end
          end else begin
            ld_cnt_d = ld_cnt_q;
          end
        end
        ST_EXPAND: begin
          if (out_ready) begin
            for (int k = 0; k < 15; k++) begin
              win_d[k] = win_q[k+1];
            end
            win_d[15] = w_next_s;
            if (t_q == T_LAST) begin
              // Block done; the next block starts loading, no overlap.
              state_d = ST_LOAD;
              t_d = '0;
            end else begin
              t_d = t_q + {{(T_W-1){1'b0}}, 1'b1};
            end
          end else begin
            t_d = t_q;
          end
        end
        default: begin
          state_d = ST_IDLE;
        end
      endcase
    end
    // Outputs are registered: decode them from the next state.
    in_ready_d = (state_d == ST_LOAD);
    out_valid_d = (state_d == ST_EXPAND);
    out_last_d = (state_d == ST_EXPAND) && (t_d == T_LAST);
    busy_d = (state_d != ST_IDLE);
  end

  // State, counters, window and output flops; async active-low reset.
  always_ff @(posedge clock or negedge reset) begin
    if (!reset) begin
      state_q <= ST_IDLE;
      ld_cnt_q <= 5'd0;
      t_q <= '0;
      for (int k = 0; k < 16; k++) begin
        win_q[k] <= '0;
      end
      in_ready_q <= 1'b0;
      out_valid_q <= 1'b0;
      out_last_q <= 1'b0;
      busy_q <= 1'b0;
    end else begin
      state_q <= state_d;
      ld_cnt_q <= ld_cnt_d;
      t_q <= t_d;
      for (int k = 0; k < 16; k++) begin
        win_q[k] <= win_d[k];
      end
      in_ready_q <= in_ready_d;
      out_valid_q <= out_valid_d;
      out_last_q <= out_last_d;
      busy_q <= busy_d;
    end
  end

  assign in_ready = in_ready_q;
  assign out_valid = out_valid_q;
  assign out_last = out_last_q;
  assign busy = busy_q;
  // The head of the window is W[t]; it is a flop, so out_data is registered.
  assign out_data = win_q[0];

endmodule
